// File: rtl/matrix_elem_tx_formatter.sv
// Formats signed matrix elements into ASCII bytes for a byte-wide UART transmitter.
// Define MATRIX_TX_RIGHT_ALIGN_EN to right-align padded fields (default: left-aligned).
module matrix_elem_tx_formatter #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 3,
    parameter int FIELD_W    = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [1:0]                    in_op,
    input  logic                          in_last_col,
    output logic                          elem_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = 4 * NUM_DIGITS;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  FIELD_W8 = 8'(FIELD_W);
`ifdef MATRIX_TX_RIGHT_ALIGN_EN
    localparam bit RIGHT_ALIGN = 1'b1;
`else
    localparam bit RIGHT_ALIGN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CONVERT, EMIT, WAIT_TX, DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        op;
        logic              last;
    } entry_t;

    state_t state, state_n;

    // ---------------- input queue ----------------
    entry_t      mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;
    entry_t      head;

    assign fifo_count = wr_ptr - rd_ptr;
    assign full       = (fifo_count == FULL_CNT);
    assign empty      = (fifo_count == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign pop        = (state == IDLE) && !empty;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign busy       = (state != IDLE) || !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: queue storage is deliberately not reset; the pointers alone define valid entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{data: in_data, op: in_op, last: in_last_col};
    end

    // ---------------- datapath ----------------
    logic [DATA_W-1:0] mag_q;
    logic [BW-1:0]     bcd_q, bcd_adj;
    logic [4:0]        cyc_q;
    logic [7:0]        idx_q;
    logic              neg_q, pad_q, last_q, nl_only_q, wait_first_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q <= '0; bcd_q <= '0; cyc_q <= '0; idx_q <= '0;
            neg_q <= 1'b0; pad_q <= 1'b0; last_q <= 1'b0; nl_only_q <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    nl_only_q <= (head.op == 2'b01);
                    neg_q     <= (head.op != 2'b01) && head.data[DATA_W-1];
                    mag_q     <= head.data[DATA_W-1] ? (~head.data + DATA_W'(1)) : head.data;
                    pad_q     <= (head.op == 2'b00) || (head.op == 2'b11);
                    last_q    <= head.last || (head.op == 2'b01);
                    bcd_q     <= '0;
                    cyc_q     <= '0;
                    idx_q     <= '0;
                end
                CONVERT: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    cyc_q          <= cyc_q + 5'd1;
                end
                EMIT: if (!tx_busy) begin
                    idx_q        <= idx_q + 8'd1;
                    wait_first_q <= 1'b1;
                end
                WAIT_TX: wait_first_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Field layout: [lead spaces][sign][digits][trail spaces][LF]
    logic [7:0] nd, body, pad, lead, total, k, dsel, ch;
    logic [3:0] digit;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        nd = 8'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd_q[4*i +: 4] != 4'd0) nd = 8'(i + 1);
        if (nd == 8'd0) nd = 8'd1;
        body  = nl_only_q ? 8'd0 : nd + {7'd0, neg_q};
        pad   = (pad_q && FIELD_W8 > body) ? FIELD_W8 - body : 8'd0;
        lead  = RIGHT_ALIGN ? pad : 8'd0;
        total = pad + body + {7'd0, last_q};
        k     = idx_q - lead;
        dsel  = nd - 8'd1 - (k - {7'd0, neg_q});
        digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (dsel == 8'(i)) digit = bcd_q[4*i +: 4];
        if (idx_q < lead)                     ch = 8'h20;
        else if (idx_q < lead + body)         ch = (neg_q && k == 8'd0) ? 8'h2D : (8'h30 | {4'd0, digit});
        else if (idx_q < pad + body)          ch = 8'h20;
        else                                  ch = 8'h0A;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        tx_start  = 1'b0;
        tx_data   = 8'h00;
        elem_done = 1'b0;
        case (state)
            IDLE:    if (!empty) state_n = (head.op == 2'b01) ? EMIT : CONVERT;
            CONVERT: if (cyc_q == 5'(DATA_W - 1)) state_n = EMIT;
            EMIT: if (!tx_busy) begin
                tx_start = 1'b1;
                tx_data  = ch;
                state_n  = WAIT_TX;
            end
            // The UART raises tx_busy one cycle late, so the first WAIT_TX cycle is skipped.
            WAIT_TX: if (!wait_first_q && !tx_busy) state_n = (idx_q == total) ? DONE : EMIT;
            DONE: begin
                elem_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_matrix_elem_tx_formatter.sv
// Scoreboard bench: two formatter instances (FIELD_W 5 and 2) driven by a simple UART model.
module tb_matrix_elem_tx_formatter;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          a_valid, a_ready, a_last, a_done, a_busy, a_start, a_txbusy, a_hold;
    logic [DW-1:0] a_data;
    logic [1:0]    a_op;
    logic [2:0]    a_cnt;
    logic [7:0]    a_txd;
    logic          b_valid, b_ready, b_last, b_done, b_busy, b_start, b_txbusy;
    logic [DW-1:0] b_data;
    logic [1:0]    b_op;
    logic [2:0]    b_cnt;
    logic [7:0]    b_txd;

    matrix_elem_tx_formatter #(.DATA_W(DW), .NUM_DIGITS(3), .FIELD_W(5), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_op(a_op), .in_last_col(a_last), .elem_done(a_done), .busy(a_busy),
        .fifo_count(a_cnt), .tx_data(a_txd), .tx_start(a_start), .tx_busy(a_txbusy));

    matrix_elem_tx_formatter #(.DATA_W(DW), .NUM_DIGITS(3), .FIELD_W(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_op(b_op), .in_last_col(b_last), .elem_done(b_done), .busy(b_busy),
        .fifo_count(b_cnt), .tx_data(b_txd), .tx_start(b_start), .tx_busy(b_txbusy));

    // UART model: busy from the cycle after tx_start for three cycles, plus a forced hold.
    logic [1:0] a_ucnt, b_ucnt;
    always @(posedge clk) begin
        if (rst) begin
            a_ucnt <= 2'd0; b_ucnt <= 2'd0;
        end else begin
            a_ucnt <= a_start ? 2'd3 : (a_ucnt != 2'd0 ? a_ucnt - 2'd1 : 2'd0);
            b_ucnt <= b_start ? 2'd3 : (b_ucnt != 2'd0 ? b_ucnt - 2'd1 : 2'd0);
        end
    end
    assign a_txbusy = a_hold || (a_ucnt != 2'd0);
    assign b_txbusy = (b_ucnt != 2'd0);

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int a_bytes = 0, a_dones = 0, b_dones = 0, exp_dones_a = 0, exp_dones_b = 0;
    logic a_prev = 1'b0, b_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference text for one entry, built with plain string formatting.
    function automatic string fmt(input int v, input logic [1:0] op, input bit last, input int fw);
        string s = "";
        if (op != 2'b01) begin
            s = $sformatf("%0d", v);
            if (op != 2'b10)
                while (s.len() < fw)
`ifdef MATRIX_TX_RIGHT_ALIGN_EN
                    s = {" ", s};
`else
                    s = {s, " "};
`endif
        end
        if (last || op == 2'b01) s = {s, "\n"};
        return s;
    endfunction

    always @(negedge clk) begin
        if (a_start) begin
            check("a_back_to_back", a_prev, 0);
            check("a_unexpected_byte", exp_a.size() != 0, 1);
            if (exp_a.size() != 0) check("a_byte", a_txd, exp_a.pop_front());
            a_bytes++;
        end
        if (b_start) begin
            check("b_back_to_back", b_prev, 0);
            check("b_unexpected_byte", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) check("b_byte", b_txd, exp_b.pop_front());
        end
        if (a_done) a_dones++;
        if (b_done) b_dones++;
        a_prev <= a_start;
        b_prev <= b_start;
    end

    task automatic push(input bit sel_b, input int v, input logic [1:0] op, input bit last,
                        input bit expect_ready);
        string s;
        s = fmt(v, op, last, sel_b ? 2 : 5);
        if (!sel_b) begin
            a_valid = 1'b1; a_data = v[DW-1:0]; a_op = op; a_last = last;
            check("a_in_ready", a_ready, expect_ready);
            if (a_ready) begin
                for (int i = 0; i < s.len(); i++) exp_a.push_back(s[i]);
                exp_dones_a++;
            end
        end else begin
            b_valid = 1'b1; b_data = v[DW-1:0]; b_op = op; b_last = last;
            check("b_in_ready", b_ready, expect_ready);
            if (b_ready) begin
                for (int i = 0; i < s.len(); i++) exp_b.push_back(s[i]);
                exp_dones_b++;
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel_b);
        int n = 0;
        while (n < 800 && (sel_b ? (exp_b.size() != 0 || b_busy) : (exp_a.size() != 0 || a_busy))) begin
            @(posedge clk); #1;
            n++;
        end
        check(sel_b ? "b_drain_timeout" : "a_drain_timeout", n < 800, 1);
        repeat (2) @(posedge clk);
        #1;
        check(sel_b ? "b_elem_done_count" : "a_elem_done_count",
              sel_b ? b_dones : a_dones, sel_b ? exp_dones_b : exp_dones_a);
    endtask

    task automatic measure_latency(input string tag, input int expected);
        int lat = 1;
        while (!a_start && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check(tag, lat, expected);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int n;
        int db;
        rst = 1'b1; a_hold = 1'b0;
        a_valid = 1'b0; a_data = '0; a_op = 2'b00; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_op = 2'b00; b_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", a_ready, 1);
        check("rst_fifo_count", a_cnt, 0);
        check("rst_tx_start", a_start, 0);
        check("rst_tx_data", a_txd, 8'h00);
        check("rst_elem_done", a_done, 0);
        check("rst_busy", a_busy, 0);
        check("rst_b_busy", b_busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Most negative value, with first-byte latency.
        push(0, -128, 2'b00, 0, 1);
        measure_latency("latency_number", DW + 2);
        wait_idle(0);

        // Zero, then positive maximum ending a row.
        push(0, 0, 2'b00, 0, 1);
        push(0, 127, 2'b00, 1, 1);
        wait_idle(0);

        // Newline-only latency, op 11 as padded, raw negative with LF.
        push(0, 0, 2'b01, 0, 1);
        measure_latency("latency_newline", 2);
        push(0, 42, 2'b11, 0, 1);
        push(0, -5, 2'b10, 1, 1);
        push(0, -5, 2'b00, 0, 1);
        wait_idle(0);

        // Narrow field: no truncation, raw number with LF.
        push(1, -100, 2'b00, 0, 1);
        push(1, 7, 2'b10, 1, 1);
        push(1, 3, 2'b00, 0, 1);
        wait_idle(1);

        // Back-pressure: hold the UART busy so the queue fills behind a stalled entry.
        a_hold = 1'b1;
        push(0, 9, 2'b00, 0, 1);
        repeat (DW + 4) @(posedge clk);
        #1;
        check("full_pre_count", a_cnt, 0);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_ready) acc++;
            push(0, (i % 2) ? -(i + 1) : (i + 1), 2'b00, 0, i < 4);
        end
        check("full_accepted", acc, 4);
        check("full_count", a_cnt, 4);
        check("full_in_ready", a_ready, 0);
        a_hold = 1'b0;
        n = 0;
        while (a_cnt != 3'd3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("full_drain_to_3", a_cnt, 3);
        wait_idle(0);

        // Reset in the middle of an entry after its second byte.
        push(0, -128, 2'b00, 0, 1);
        n = 0;
        while (a_bytes < 2 + exp_dones_a * 0 && n < 0) n++;
        db = a_bytes;
        n = 0;
        while (a_bytes < db + 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_second_byte_seen", a_bytes, db + 2);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_a.delete();
        db = a_dones;
        repeat (2) @(posedge clk);
        #1;
        check("abort_fifo_count", a_cnt, 0);
        check("abort_busy", a_busy, 0);
        check("abort_tx_start", a_start, 0);
        rst = 1'b0;
        n = a_bytes;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_bytes", a_bytes, n);
        check("abort_no_elem_done", a_dones, db);

        check("a_scoreboard_empty", exp_a.size(), 0);
        check("b_scoreboard_empty", exp_b.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
